// File: rtl/dual_port_data_memory_if.sv
// Load/store bus between the two MEM-stage issue slots and the data memory.
// en is the request valid; there is no ready, every request is taken; rvalid/err pulse one cycle later.
interface dual_port_data_memory_if #(
    parameter int DATA_WIDTH = 32
) ();
    localparam int NBYTES = DATA_WIDTH / 8;

    logic                  a_en;
    logic                  a_we;
    logic [NBYTES-1:0]     a_be;
    logic [31:0]           a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic [DATA_WIDTH-1:0] a_rdata;
    logic                  a_rvalid;
    logic                  a_err;

    logic                  b_en;
    logic                  b_we;
    logic [NBYTES-1:0]     b_be;
    logic [31:0]           b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic [DATA_WIDTH-1:0] b_rdata;
    logic                  b_rvalid;
    logic                  b_err;

    modport master (
        output a_en, a_we, a_be, a_addr, a_wdata,
        output b_en, b_we, b_be, b_addr, b_wdata,
        input  a_rdata, a_rvalid, a_err,
        input  b_rdata, b_rvalid, b_err
    );

    modport slave (
        input  a_en, a_we, a_be, a_addr, a_wdata,
        input  b_en, b_we, b_be, b_addr, b_wdata,
        output a_rdata, a_rvalid, a_err,
        output b_rdata, b_rvalid, b_err
    );
endinterface

// File: rtl/dual_port_data_memory.sv
// Two-port byte-writable data memory with registered reads, cross-port write
// forwarding and an error pulse for out-of-range or misaligned accesses.
module dual_port_data_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    dual_port_data_memory_if.slave   bus
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(NBYTES);
    localparam int IDX    = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  a_ok, b_ok;
    logic                  a_wr, b_wr;
    logic                  a_rd, b_rd;
    logic [IDX-1:0]        a_idx, b_idx;
    logic [DATA_WIDTH-1:0] a_fwd, b_fwd;

    logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;
    logic                  a_rvalid_q, b_rvalid_q;
    logic                  a_err_q, b_err_q;

    // Writes must start at their lowest enabled lane; reads ignore the offset.
    function automatic logic access_ok(input logic we, input logic [NBYTES-1:0] be,
                                       input logic [31:0] addr);
        logic ok;
        logic found;
        ok    = ((addr >> (OFFS + IDX)) == 32'd0);
        found = 1'b0;
        if (we) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (be[i] && !found) begin
                    found = 1'b1;
                    if (int'(addr[OFFS-1:0]) != i) ok = 1'b0;
                end
            end
        end
        return ok;
    endfunction

    always_comb begin
        a_ok  = access_ok(bus.a_we, bus.a_be, bus.a_addr);
        b_ok  = access_ok(bus.b_we, bus.b_be, bus.b_addr);
        a_idx = bus.a_addr[OFFS+IDX-1:OFFS];
        b_idx = bus.b_addr[OFFS+IDX-1:OFFS];
        a_wr  = bus.a_en &&  bus.a_we && a_ok;
        b_wr  = bus.b_en &&  bus.b_we && b_ok;
        a_rd  = bus.a_en && !bus.a_we && a_ok;
        b_rd  = bus.b_en && !bus.b_we && b_ok;

        // A read sees the other port's same-cycle write lanes.
        a_fwd = mem[a_idx];
        b_fwd = mem[b_idx];
        for (int i = 0; i < NBYTES; i++) begin
            if (b_wr && bus.b_be[i] && (b_idx == a_idx)) a_fwd[8*i +: 8] = bus.b_wdata[8*i +: 8];
            if (a_wr && bus.a_be[i] && (a_idx == b_idx)) b_fwd[8*i +: 8] = bus.a_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_err_q    <= 1'b0;
            b_err_q    <= 1'b0;
        end else begin
            a_rvalid_q <= a_rd;
            b_rvalid_q <= b_rd;
            a_err_q    <= bus.a_en && !a_ok;
            b_err_q    <= bus.b_en && !b_ok;
            if (a_rd) a_rdata_q <= a_fwd;
            if (b_rd) b_rdata_q <= b_fwd;
            // Port B is issued last so its lanes win where both ports write.
            for (int i = 0; i < NBYTES; i++) begin
                if (a_wr && bus.a_be[i]) mem[a_idx][8*i +: 8] <= bus.a_wdata[8*i +: 8];
            end
            for (int i = 0; i < NBYTES; i++) begin
                if (b_wr && bus.b_be[i]) mem[b_idx][8*i +: 8] <= bus.b_wdata[8*i +: 8];
            end
        end
    end

    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rdata  = b_rdata_q;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.a_err    = a_err_q;
    assign bus.b_err    = b_err_q;
endmodule

// File: tb/tb_dual_port_data_memory.sv
// Directed vector table on a 32x64 instance, random dual-port traffic on a
// 64x16 instance against a byte-array reference model.
module tb_dual_port_data_memory;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dual_port_data_memory_if #(.DATA_WIDTH(32)) bus0 ();
    dual_port_data_memory_if #(.DATA_WIDTH(64)) bus1 ();

    dual_port_data_memory #(.DATA_WIDTH(32), .DEPTH(64)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    dual_port_data_memory #(.DATA_WIDTH(64), .DEPTH(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- directed vectors (32-bit, 64 words) ----------------
    typedef struct {
        logic [1:0]  a_op;  // 0 idle, 1 read, 2 write
        logic [3:0]  a_be;
        logic [31:0] a_addr;
        logic [31:0] a_wd;
        logic [1:0]  b_op;
        logic [3:0]  b_be;
        logic [31:0] b_addr;
        logic [31:0] b_wd;
        logic        ea_rv, ea_err;
        logic [31:0] ea_rd;
        logic        eb_rv, eb_err;
        logic [31:0] eb_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [1:0] a_op, input logic [3:0] a_be, input logic [31:0] a_addr, input logic [31:0] a_wd,
        input logic [1:0] b_op, input logic [3:0] b_be, input logic [31:0] b_addr, input logic [31:0] b_wd,
        input logic ea_rv, input logic ea_err, input logic [31:0] ea_rd,
        input logic eb_rv, input logic eb_err, input logic [31:0] eb_rd);
        vec_t v;
        v.a_op = a_op; v.a_be = a_be; v.a_addr = a_addr; v.a_wd = a_wd;
        v.b_op = b_op; v.b_be = b_be; v.b_addr = b_addr; v.b_wd = b_wd;
        v.ea_rv = ea_rv; v.ea_err = ea_err; v.ea_rd = ea_rd;
        v.eb_rv = eb_rv; v.eb_err = eb_err; v.eb_rd = eb_rd;
        return v;
    endfunction

    task automatic drive0(input vec_t v);
        bus0.a_en = (v.a_op != 2'd0); bus0.a_we = (v.a_op == 2'd2);
        bus0.a_be = v.a_be; bus0.a_addr = v.a_addr; bus0.a_wdata = v.a_wd;
        bus0.b_en = (v.b_op != 2'd0); bus0.b_we = (v.b_op == 2'd2);
        bus0.b_be = v.b_be; bus0.b_addr = v.b_addr; bus0.b_wdata = v.b_wd;
    endtask

    task automatic idle0();
        bus0.a_en = 1'b0; bus0.a_we = 1'b0; bus0.a_be = '0; bus0.a_addr = '0; bus0.a_wdata = '0;
        bus0.b_en = 1'b0; bus0.b_we = 1'b0; bus0.b_be = '0; bus0.b_addr = '0; bus0.b_wdata = '0;
    endtask

    task automatic idle1();
        bus1.a_en = 1'b0; bus1.a_we = 1'b0; bus1.a_be = '0; bus1.a_addr = '0; bus1.a_wdata = '0;
        bus1.b_en = 1'b0; bus1.b_we = 1'b0; bus1.b_be = '0; bus1.b_addr = '0; bus1.b_wdata = '0;
    endtask

    task automatic check0(input string tag, input logic ea_rv, input logic ea_err, input logic [31:0] ea_rd,
                          input logic eb_rv, input logic eb_err, input logic [31:0] eb_rd);
        chk({tag, " a_rvalid"}, 64'(bus0.a_rvalid), 64'(ea_rv));
        chk({tag, " a_err"},    64'(bus0.a_err),    64'(ea_err));
        chk({tag, " a_rdata"},  64'(bus0.a_rdata),  64'(ea_rd));
        chk({tag, " b_rvalid"}, 64'(bus0.b_rvalid), 64'(eb_rv));
        chk({tag, " b_err"},    64'(bus0.b_err),    64'(eb_err));
        chk({tag, " b_rdata"},  64'(bus0.b_rdata),  64'(eb_rd));
    endtask

    // ---------------- reference model for the 64-bit, 16-word instance ----------------
    logic [63:0]  m_mem [16];
    logic [63:0]  m_ard, m_brd;
    logic [131:0] exp_q[$];

    function automatic int lowest(input logic [7:0] be);
        for (int i = 0; i < 8; i++) if (be[i]) return i;
        return 0;
    endfunction

    function automatic bit m_legal(input logic we, input logic [7:0] be, input logic [31:0] addr);
        if (addr >= 32'd128) return 1'b0;
        if (!we || be == 8'd0) return 1'b1;
        return (int'(addr % 8) == lowest(be));
    endfunction

    task automatic model_step();
        logic [63:0] nm [16];
        bit a_ok, b_ok, a_rv, b_rv;
        a_ok = m_legal(bus1.a_we, bus1.a_be, bus1.a_addr);
        b_ok = m_legal(bus1.b_we, bus1.b_be, bus1.b_addr);
        nm = m_mem;
        for (int i = 0; i < 8; i++)
            if (bus1.a_en && bus1.a_we && a_ok && bus1.a_be[i])
                nm[bus1.a_addr[6:3]][8*i +: 8] = bus1.a_wdata[8*i +: 8];
        for (int i = 0; i < 8; i++)
            if (bus1.b_en && bus1.b_we && b_ok && bus1.b_be[i])
                nm[bus1.b_addr[6:3]][8*i +: 8] = bus1.b_wdata[8*i +: 8];
        a_rv = bus1.a_en && !bus1.a_we && a_ok;
        b_rv = bus1.b_en && !bus1.b_we && b_ok;
        if (a_rv) m_ard = nm[bus1.a_addr[6:3]];
        if (b_rv) m_brd = nm[bus1.b_addr[6:3]];
        exp_q.push_back({a_rv, bus1.a_en && !a_ok, m_ard, b_rv, bus1.b_en && !b_ok, m_brd});
        m_mem = nm;
    endtask

    task automatic gen_port(output logic en, output logic we, output logic [7:0] be,
                            output logic [31:0] addr, output logic [63:0] wd,
                            input logic [3:0] fidx, input bit use_f);
        logic [3:0] idx;
        int off;
        en   = ($urandom_range(0, 3) != 0);
        we   = 1'($urandom_range(0, 1));
        be   = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
        idx  = use_f ? fidx : 4'($urandom_range(0, 15));
        off  = (we && be != 8'd0 && $urandom_range(0, 7) != 0) ? lowest(be) : int'($urandom_range(0, 7));
        addr = 32'(idx) * 32'd8 + 32'(off);
        if ($urandom_range(0, 15) == 0) addr = addr | (32'h80 << $urandom_range(0, 24));
        wd   = {$urandom, $urandom};
    endtask

    task automatic check1(input int cyc);
        logic [131:0] e;
        e = exp_q.pop_front();
        chk($sformatf("rnd%0d a_rvalid", cyc), 64'(bus1.a_rvalid), 64'(e[131]));
        chk($sformatf("rnd%0d a_err", cyc),    64'(bus1.a_err),    64'(e[130]));
        chk($sformatf("rnd%0d a_rdata", cyc),  bus1.a_rdata,       e[129:66]);
        chk($sformatf("rnd%0d b_rvalid", cyc), 64'(bus1.b_rvalid), 64'(e[65]));
        chk($sformatf("rnd%0d b_err", cyc),    64'(bus1.b_err),    64'(e[64]));
        chk($sformatf("rnd%0d b_rdata", cyc),  bus1.b_rdata,       e[63:0]);
    endtask

    initial begin
        logic        en, we;
        logic [7:0]  be;
        logic [31:0] addr;
        logic [63:0] wd;
        logic [3:0]  aidx;

        // ---- clock / reset ----
        rst_n = 1'b0;
        idle0();
        idle1();
        repeat (2) @(posedge clk);
        #1;
        check0("reset", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("reset dut1 a_rdata", bus1.a_rdata, 64'd0);
        chk("reset dut1 b_rvalid", 64'(bus1.b_rvalid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- directed table ----
        vecs.push_back(mk(2, 4'hF, 32'h10,  32'hDEADBEEF, 0, 4'h0, 32'h0,  32'h0,        0,0,32'h0,        0,0,32'h0));
        vecs.push_back(mk(0, 4'h0, 32'h0,   32'h0,        1, 4'h0, 32'h10, 32'h0,        0,0,32'h0,        1,0,32'hDEADBEEF));
        vecs.push_back(mk(2, 4'hF, 32'h20,  32'h11223344, 0, 4'h0, 32'h0,  32'h0,        0,0,32'h0,        0,0,32'hDEADBEEF));
        vecs.push_back(mk(2, 4'h3, 32'h20,  32'h0000AAAA, 2, 4'h6, 32'h21, 32'h00BBBB00, 0,0,32'h0,        0,0,32'hDEADBEEF));
        vecs.push_back(mk(1, 4'h0, 32'h20,  32'h0,        0, 4'h0, 32'h0,  32'h0,        1,0,32'h11BBBBAA, 0,0,32'hDEADBEEF));
        vecs.push_back(mk(2, 4'hF, 32'h8,   32'h0,        2, 4'hF, 32'h0,  32'hCAFEF00D, 0,0,32'h11BBBBAA, 0,0,32'hDEADBEEF));
        vecs.push_back(mk(2, 4'hF, 32'h8,   32'h12345678, 1, 4'h0, 32'h8,  32'h0,        0,0,32'h11BBBBAA, 1,0,32'h12345678));
        vecs.push_back(mk(1, 4'h0, 32'h100, 32'h0,        0, 4'h0, 32'h0,  32'h0,        0,1,32'h11BBBBAA, 0,0,32'h12345678));
        vecs.push_back(mk(0, 4'h0, 32'h0,   32'h0,        2, 4'hF, 32'h2,  32'hFFFFFFFF, 0,0,32'h11BBBBAA, 0,1,32'h12345678));
        vecs.push_back(mk(1, 4'h0, 32'h0,   32'h0,        0, 4'h0, 32'h0,  32'h0,        1,0,32'hCAFEF00D, 0,0,32'h12345678));
        vecs.push_back(mk(0, 4'h0, 32'h0,   32'h0,        2, 4'h4, 32'h2,  32'h00550000, 0,0,32'hCAFEF00D, 0,0,32'h12345678));
        vecs.push_back(mk(1, 4'h0, 32'h3,   32'h0,        1, 4'h0, 32'h8,  32'h0,        1,0,32'hCA55F00D, 1,0,32'h12345678));
        vecs.push_back(mk(1, 4'h0, 32'h10,  32'h0,        1, 4'h0, 32'h10, 32'h0,        1,0,32'hDEADBEEF, 1,0,32'hDEADBEEF));
        vecs.push_back(mk(0, 4'h0, 32'h0,   32'h0,        2, 4'h0, 32'h13, 32'h12121212, 0,0,32'hDEADBEEF, 0,0,32'hDEADBEEF));
        vecs.push_back(mk(2, 4'h1, 32'h1,   32'h000000EE, 2, 4'h8, 32'h3,  32'h77000000, 0,1,32'hDEADBEEF, 0,0,32'hDEADBEEF));
        vecs.push_back(mk(1, 4'h0, 32'h0,   32'h0,        1, 4'h0, 32'h0,  32'h0,        1,0,32'h7755F00D, 1,0,32'h7755F00D));
        vecs.push_back(mk(1, 4'h0, 32'h10,  32'h0,        2, 4'hC, 32'h12, 32'h99880000, 1,0,32'h9988BEEF, 0,0,32'h7755F00D));
        vecs.push_back(mk(0, 4'h0, 32'h0,   32'h0,        1, 4'h0, 32'h10, 32'h0,        0,0,32'h9988BEEF, 1,0,32'h9988BEEF));

        for (int i = 0; i < vecs.size(); i++) begin
            drive0(vecs[i]);
            @(posedge clk);
            #1;
            check0($sformatf("vec%0d", i), vecs[i].ea_rv, vecs[i].ea_err, vecs[i].ea_rd,
                   vecs[i].eb_rv, vecs[i].eb_err, vecs[i].eb_rd);
        end

        // ---- reset between request and response edge ----
        drive0(mk(1, 4'h0, 32'h20, 32'h0, 1, 4'h0, 32'h8, 32'h0, 0,0,32'h0, 0,0,32'h0));
        #3;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check0("rst_mid", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        idle0();
        @(negedge clk);
        rst_n = 1'b1;
        drive0(mk(1, 4'h0, 32'h10, 32'h0, 1, 4'h0, 32'h20, 32'h0, 0,0,32'h0, 0,0,32'h0));
        @(posedge clk);
        #1;
        check0("post_rst", 1'b1, 1'b0, 32'h9988BEEF, 1'b1, 1'b0, 32'h11BBBBAA);
        idle0();
        @(posedge clk);
        #1;
        check0("hold", 1'b0, 1'b0, 32'h9988BEEF, 1'b0, 1'b0, 32'h11BBBBAA);

        // ---- random traffic on the 64-bit x 16 instance ----
        m_ard = '0;
        m_brd = '0;
        for (int w = 0; w < 8; w++) begin
            bus1.a_en = 1'b1; bus1.a_we = 1'b1; bus1.a_be = 8'hFF;
            bus1.a_addr = 32'(2 * w) * 32'd8; bus1.a_wdata = {$urandom, $urandom};
            bus1.b_en = 1'b1; bus1.b_we = 1'b1; bus1.b_be = 8'hFF;
            bus1.b_addr = 32'(2 * w + 1) * 32'd8; bus1.b_wdata = {$urandom, $urandom};
            model_step();
            @(posedge clk);
            #1;
            check1(w);
        end
        for (int c = 0; c < 400; c++) begin
            gen_port(en, we, be, addr, wd, 4'd0, 1'b0);
            bus1.a_en = en; bus1.a_we = we; bus1.a_be = be; bus1.a_addr = addr; bus1.a_wdata = wd;
            aidx = addr[6:3];
            gen_port(en, we, be, addr, wd, aidx, ($urandom_range(0, 2) == 0));
            bus1.b_en = en; bus1.b_we = we; bus1.b_be = be; bus1.b_addr = addr; bus1.b_wdata = wd;
            model_step();
            @(posedge clk);
            #1;
            check1(c + 8);
        end
        idle1();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
